// File: rtl/sram_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_access_ctrl: request-side controller for a 16x(4b tag, 8b data)      |
// | SRAM with per-entry valid bits and registered read/hit responses.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module sram_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [3:0]  req_addr,
  input  logic [3:0]  req_tag,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_hit,
  output logic [3:0]  rsp_tag,
  output logic [7:0]  rsp_data,
  output logic        sram_we,
  output logic [15:0] sram_wl,
  output logic [3:0]  sram_tag_in,
  output logic [7:0]  sram_data_in,
  input  logic [3:0]  sram_tag_out,
  input  logic [7:0]  sram_data_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] C_OP_WRITE = 2'b01;
  localparam logic [1:0] C_OP_INV   = 2'b10;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_op;
  logic [3:0]  r_addr;
  logic [3:0]  r_tag;
  logic [7:0]  r_data;
  logic [15:0] r_valid;
  logic        r_rsp_hit;
  logic [3:0]  r_rsp_tag;
  logic [7:0]  r_rsp_data;

  logic w_is_write;
  logic w_is_inv;
  logic w_in_access;
  logic w_rd_hit;

  assign w_is_write  = (r_op == C_OP_WRITE);
  assign w_is_inv    = (r_op == C_OP_INV);
  assign w_in_access = (r_state == S_ACCESS);
  // Only the controller's valid bit qualifies a hit; SRAM contents are never reset.
  assign w_rd_hit    = r_valid[r_addr] && (sram_tag_out == r_tag);

  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    sram_we      = 1'b0;
    sram_wl      = 16'h0000;
    sram_tag_in  = 4'h0;
    sram_data_in = 8'h00;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        sram_we      = w_is_write && !reset;
        sram_wl      = w_is_inv ? 16'h0000 : (16'h0001 << r_addr);
        sram_tag_in  = r_tag;
        sram_data_in = r_data;
        w_next       = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= 2'b00;
      r_addr     <= 4'h0;
      r_tag      <= 4'h0;
      r_data     <= 8'h00;
      r_valid    <= 16'h0000;
      r_rsp_hit  <= 1'b0;
      r_rsp_tag  <= 4'h0;
      r_rsp_data <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req_valid) begin
        r_op   <= req_op;
        r_addr <= req_addr;
        r_tag  <= req_tag;
        r_data <= req_data;
      end
      if (w_in_access) begin
        if (w_is_write) begin
          r_valid[r_addr] <= 1'b1;
          r_rsp_hit       <= 1'b1;
          r_rsp_tag       <= r_tag;
          r_rsp_data      <= r_data;
        end else if (w_is_inv) begin
          r_valid[r_addr] <= 1'b0;
          r_rsp_hit       <= 1'b1;
          r_rsp_tag       <= 4'h0;
          r_rsp_data      <= 8'h00;
        end else begin
          r_rsp_hit  <= w_rd_hit;
          r_rsp_tag  <= sram_tag_out;
          r_rsp_data <= w_rd_hit ? sram_data_out : 8'h00;
        end
      end
    end
  end

  assign rsp_hit  = r_rsp_hit;
  assign rsp_tag  = r_rsp_tag;
  assign rsp_data = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_access_ctrl: randomized bench with a behavioural SRAM and model.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_addr, req_tag;
  logic [7:0]  req_data;
  logic        rsp_valid, rsp_ready, rsp_hit;
  logic [3:0]  rsp_tag;
  logic [7:0]  rsp_data;
  logic        sram_we;
  logic [15:0] sram_wl;
  logic [3:0]  sram_tag_in, sram_tag_out;
  logic [7:0]  sram_data_in, sram_data_out;

  int total = 0;
  int bad   = 0;

  // Behavioural SRAM with combinational read.
  logic [3:0] mem_tag [16];
  logic [7:0] mem_data[16];
  // Reference state: what the SRAM should hold and which entries are valid.
  logic [3:0] ref_tag [16];
  logic [7:0] ref_data[16];
  logic       ref_valid[16];

  always #5 clk = ~clk;

  sram_access_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_tag(req_tag), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .sram_we(sram_we), .sram_wl(sram_wl),
    .sram_tag_in(sram_tag_in), .sram_data_in(sram_data_in),
    .sram_tag_out(sram_tag_out), .sram_data_out(sram_data_out)
  );

  always @(posedge clk) begin
    if (sram_we) begin
      for (int i = 0; i < 16; i++) begin
        if (sram_wl[i]) begin
          mem_tag[i]  <= sram_tag_in;
          mem_data[i] <= sram_data_in;
        end
      end
    end
  end

  always_comb begin
    sram_tag_out  = 4'h0;
    sram_data_out = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (sram_wl[i]) begin
        sram_tag_out  = mem_tag[i];
        sram_data_out = mem_data[i];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one request starting at #1 after an edge; checks ACCESS, RESP
  // (including hold cycles) and the return to idle.
  task automatic run_req(input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] t, input logic [7:0] d, input int hold);
    logic        e_hit, e_we;
    logic [3:0]  e_tag;
    logic [7:0]  e_data;
    logic [15:0] e_wl;
    if (op == 2'b01) begin
      e_hit = 1'b1; e_tag = t; e_data = d;
    end else if (op == 2'b10) begin
      e_hit = 1'b1; e_tag = 4'h0; e_data = 8'h00;
    end else begin
      e_hit  = ref_valid[a] && (ref_tag[a] == t);
      e_tag  = ref_tag[a];
      e_data = e_hit ? ref_data[a] : 8'h00;
    end
    e_we = (op == 2'b01);
    e_wl = (op == 2'b10) ? 16'h0000 : (16'h0001 << a);

    req_valid = 1'b1; req_op = op; req_addr = a; req_tag = t; req_data = d;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL idle_ready: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = 4'($urandom);
    req_tag = 4'($urandom); req_data = 8'($urandom);
    total++;
    if ({req_ready, rsp_valid, sram_we, sram_wl, sram_tag_in, sram_data_in} !==
        {1'b0, 1'b0, e_we, e_wl, t, d}) begin
      bad++;
      $display("FAIL access op=%0d addr=%0d: got rdy=%b rv=%b we=%b wl=%h ti=%h di=%h want rdy=0 rv=0 we=%b wl=%h ti=%h di=%h",
               op, a, req_ready, rsp_valid, sram_we, sram_wl, sram_tag_in, sram_data_in,
               e_we, e_wl, t, d);
    end
    @(posedge clk); #1;
    if (op == 2'b01) begin
      ref_valid[a] = 1'b1; ref_tag[a] = t; ref_data[a] = d;
    end else if (op == 2'b10) begin
      ref_valid[a] = 1'b0;
    end
    total++;
    if ({mem_tag[a], mem_data[a]} !== {ref_tag[a], ref_data[a]}) begin
      bad++;
      $display("FAIL sram_contents addr=%0d: got %h/%h want %h/%h",
               a, mem_tag[a], mem_data[a], ref_tag[a], ref_data[a]);
    end
    for (int k = 0; k <= hold; k++) begin
      total++;
      if ({rsp_valid, rsp_hit, rsp_tag, rsp_data, req_ready, sram_we, sram_wl} !==
          {1'b1, e_hit, e_tag, e_data, 1'b0, 1'b0, 16'h0000}) begin
        bad++;
        $display("FAIL resp op=%0d addr=%0d cyc=%0d: got v=%b hit=%b tag=%h data=%h rdy=%b we=%b wl=%h want v=1 hit=%b tag=%h data=%h rdy=0 we=0 wl=0000",
                 op, a, k, rsp_valid, rsp_hit, rsp_tag, rsp_data, req_ready, sram_we,
                 sram_wl, e_hit, e_tag, e_data);
      end
      if (k == hold) rsp_ready = 1'b1;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      bad++; $display("FAIL return_idle: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 2'b00; req_addr = 4'h0; req_tag = 4'h0; req_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    total++;
    if ({req_ready, rsp_valid, rsp_hit, rsp_tag, rsp_data, sram_we, sram_wl, sram_tag_in, sram_data_in} !==
        {1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 16'h0000, 4'h0, 8'h00}) begin
      bad++;
      $display("FAIL reset_values: got rdy=%b v=%b hit=%b tag=%h data=%h we=%b wl=%h ti=%h di=%h want 1 0 0 0 00 0 0000 0 00",
               req_ready, rsp_valid, rsp_hit, rsp_tag, rsp_data, sram_we, sram_wl, sram_tag_in, sram_data_in);
    end
  endtask

  task automatic test_directed;
    run_req(2'b00, 4'd5, 4'd3, 8'h00, 0);   // read of invalid entry misses
    run_req(2'b01, 4'd5, 4'd3, 8'hA5, 0);
    run_req(2'b00, 4'd5, 4'd3, 8'h00, 0);
    run_req(2'b01, 4'd15, 4'd9, 8'h3C, 0);
    run_req(2'b00, 4'd15, 4'd8, 8'h00, 0);  // tag mismatch
    run_req(2'b01, 4'd0, 4'd6, 8'h11, 0);
    run_req(2'b10, 4'd0, 4'd6, 8'h00, 0);
    run_req(2'b00, 4'd0, 4'd6, 8'h00, 0);
    run_req(2'b01, 4'd4, 4'd2, 8'h5A, 0);
    run_req(2'b11, 4'd4, 4'd2, 8'h00, 0);   // reserved op reads
  endtask

  task automatic test_backpressure;
    run_req(2'b01, 4'd2, 4'd1, 8'h7E, 0);
    run_req(2'b00, 4'd2, 4'd1, 8'h00, 5);
  endtask

  task automatic test_reset_mid_access;
    req_valid = 1'b1; req_op = 2'b01; req_addr = 4'd7; req_tag = 4'd5; req_data = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (sram_we !== 1'b0) begin
      bad++; $display("FAIL reset_we_gate: got %b want 0", sram_we);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({rsp_valid, req_ready, mem_tag[7], mem_data[7]} !== {1'b0, 1'b1, ref_tag[7], ref_data[7]}) begin
        bad++;
        $display("FAIL reset_drop cyc=%0d: got v=%b rdy=%b mem=%h/%h want v=0 rdy=1 mem=%h/%h",
                 k, rsp_valid, req_ready, mem_tag[7], mem_data[7], ref_tag[7], ref_data[7]);
      end
      @(posedge clk); #1;
    end
    run_req(2'b00, 4'd7, 4'd5, 8'h00, 0);
    run_req(2'b00, 4'd2, 4'd1, 8'h00, 0);   // earlier valid entry also cleared
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      logic [1:0] op;
      logic [3:0] a, t;
      op = 2'($urandom);
      a  = 4'($urandom_range(0, 7));
      t  = ($urandom_range(0, 1) == 1) ? ref_tag[a] : 4'($urandom);
      run_req(op, a, t, 8'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_tag[i]  = 4'($urandom);
      mem_data[i] = 8'($urandom);
      ref_tag[i]  = mem_tag[i];
      ref_data[i] = mem_data[i];
      ref_valid[i] = 1'b0;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
